// File: rtl/mult_unit.sv
// Iterative 32x32 unsigned multiplier (shift-add, one step per clock) with
// architectural HI/LO registers, MFHI/MFLO readback and pipeline stall request.
module mult_unit #(
    parameter logic [5:0] FUNCT_MULTU = 6'b011001,
    parameter logic [5:0] FUNCT_MFHI  = 6'b010000,
    parameter logic [5:0] FUNCT_MFLO  = 6'b010010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        flush,
    output logic [31:0] dataOut,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [DATA_W:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                accept_c;
    logic [DATA_W:0]     addend_c;
    logic [DATA_W:0]     sum_c;
    logic [PROD_W-1:0]   step_c;

    // A new multiply is accepted only from IDLE; flush overrides the request.
    assign accept_c = (state_q == S_IDLE) && start && (funct == FUNCT_MULTU) && !flush;

    // One shift-add step: conditional 33-bit add into the upper half, then shift right.
    always_comb begin
        addend_c = prod_q[0] ? mcand_q : (DATA_W + 1)'(0);
        sum_c    = {1'b0, prod_q[PROD_W-1:DATA_W]} + addend_c;
        step_c   = {sum_c, prod_q[DATA_W-1:1]};
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    prod_d  = {DATA_W'(0), dataB};
                    mcand_d = {1'b0, dataA};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    // Abort: HI/LO untouched, no done pulse.
                    state_d = S_IDLE;
                end else begin
                    prod_d = step_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = step_c[PROD_W-1:DATA_W];
                        lo_d    = step_c[DATA_W-1:0];
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decodes and combinational stall/readback.
    always_comb begin
        busy   = (state_q == S_RUN);
        done   = (state_q == S_DONE);
        stall  = busy || accept_c;
        hi_out = hi_q;
        lo_out = lo_q;
        if (funct == FUNCT_MFHI) begin
            dataOut = hi_q;
        end else if (funct == FUNCT_MFLO) begin
            dataOut = lo_q;
        end else begin
            dataOut = '0;
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed testbench for mult_unit: vector table plus hand-written corner sequences.
module tb_mult_unit;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        flush;
    logic [31:0] dataOut;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    mult_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct   (funct),
        .dataA   (dataA),
        .dataB   (dataB),
        .flush   (flush),
        .dataOut (dataOut),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one MULTU at the current negedge (cycle 0) and observe 45 cycles.
    // restart_cyc/flush_cyc < 0 disables that event. Operand inputs carry junk after cycle 0.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input int restart_cyc, input int flush_cyc,
                            output int stall_cnt, output int busy_cnt,
                            output int done_cnt, output int done_cyc);
        stall_cnt = 0;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        for (int c = 0; c < 45; c++) begin
            start = (c == 0) || (c == restart_cyc);
            funct = start ? F_MULTU : 6'd0;
            dataA = (c == 0) ? a : $urandom;
            dataB = (c == 0) ? b : $urandom;
            flush = (c == flush_cyc);
            #1;
            if (stall) stall_cnt++;
            if (busy)  busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        funct = 6'd0;
        flush = 1'b0;
    endtask

    task automatic check_readback(input string name, input logic [31:0] hi, input logic [31:0] lo);
        funct = F_MFHI;
        #1;
        check({name, ".mfhi"}, 64'(dataOut), 64'(hi));
        funct = F_MFLO;
        #1;
        check({name, ".mflo"}, 64'(dataOut), 64'(lo));
        funct = 6'd0;
        #1;
        check({name, ".other"}, 64'(dataOut), 64'(0));
    endtask

    vec_t vecs[8];

    initial begin
        int sc, bc, dc, dcyc;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        vecs[0] = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[3] = '{32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001};
        vecs[4] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[7] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        rst   = 1'b0;
        start = 1'b0;
        funct = 6'd0;
        dataA = '0;
        dataB = '0;
        flush = 1'b0;

        // Reset state
        #3;
        check("rst.busy",  64'(busy),   64'(0));
        check("rst.done",  64'(done),   64'(0));
        check("rst.stall", 64'(stall),  64'(0));
        check("rst.hi",    64'(hi_out), 64'(0));
        check("rst.lo",    64'(lo_out), 64'(0));
        check_readback("rst", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            run_mult(vecs[i].a, vecs[i].b, -1, -1, sc, bc, dc, dcyc);
            check($sformatf("vec%0d.stall_cycles", i), 64'(sc), 64'(33));
            check($sformatf("vec%0d.busy_cycles", i),  64'(bc), 64'(32));
            check($sformatf("vec%0d.done_count", i),   64'(dc), 64'(1));
            check($sformatf("vec%0d.done_cycle", i),   64'(dcyc), 64'(33));
            check($sformatf("vec%0d.hi", i), 64'(hi_out), 64'(vecs[i].hi));
            check($sformatf("vec%0d.lo", i), 64'(lo_out), 64'(vecs[i].lo));
            check_readback($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // Second start during RUN ignored; zero multiplier clears prior result
        run_mult(32'h12345678, 32'h00000000, 5, -1, sc, bc, dc, dcyc);
        check("restart.done_count", 64'(dc), 64'(1));
        check("restart.done_cycle", 64'(dcyc), 64'(33));
        check("restart.hi", 64'(hi_out), 64'(0));
        check("restart.lo", 64'(lo_out), 64'(0));

        // Restart during RUN with a nonzero product must not corrupt it
        run_mult(32'h00000003, 32'h00000005, 7, -1, sc, bc, dc, dcyc);
        check("restart2.done_count", 64'(dc), 64'(1));
        check("restart2.lo", 64'(lo_out), 64'(32'h0000000F));

        // Flush mid-RUN: no done, HI/LO keep prior values
        prev_hi = hi_out;
        prev_lo = lo_out;
        run_mult(32'd7, 32'd9, -1, 10, sc, bc, dc, dcyc);
        check("flush.stall_cycles", 64'(sc), 64'(11));
        check("flush.busy_cycles",  64'(bc), 64'(10));
        check("flush.done_count",   64'(dc), 64'(0));
        check("flush.hi", 64'(hi_out), 64'(prev_hi));
        check("flush.lo", 64'(lo_out), 64'(prev_lo));

        // Flush in DONE has no effect
        run_mult(32'd7, 32'd9, -1, 33, sc, bc, dc, dcyc);
        check("flushdone.done_count", 64'(dc), 64'(1));
        check("flushdone.hi", 64'(hi_out), 64'(0));
        check("flushdone.lo", 64'(lo_out), 64'(63));

        // Flush together with a valid start in IDLE
        start = 1'b1;
        funct = F_MULTU;
        dataA = 32'd4;
        dataB = 32'd4;
        flush = 1'b1;
        #1;
        check("flushstart.stall", 64'(stall), 64'(0));
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        funct = 6'd0;
        #1;
        check("flushstart.busy", 64'(busy), 64'(0));
        check("flushstart.lo", 64'(lo_out), 64'(63));
        @(negedge clk);

        // Non-MULTU funct with start: no stall, no state change, dataOut 0
        start = 1'b1;
        funct = F_ADD;
        dataA = 32'd5;
        dataB = 32'd6;
        #1;
        check("add.stall",   64'(stall),   64'(0));
        check("add.dataout", 64'(dataOut), 64'(0));
        @(negedge clk);
        start = 1'b0;
        funct = 6'd0;
        #1;
        check("add.busy", 64'(busy), 64'(0));
        check("add.lo",   64'(lo_out), 64'(63));
        @(negedge clk);

        // Asynchronous reset at cycle 20 of a multiply
        start = 1'b1;
        funct = F_MULTU;
        dataA = 32'd7;
        dataB = 32'd9;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            funct = 6'd0;
        end
        #1;
        check("midrst.busy_before", 64'(busy), 64'(1));
        #1;
        rst = 1'b0;
        #1;
        check("midrst.busy",  64'(busy),   64'(0));
        check("midrst.stall", 64'(stall),  64'(0));
        check("midrst.done",  64'(done),   64'(0));
        check("midrst.hi",    64'(hi_out), 64'(0));
        check("midrst.lo",    64'(lo_out), 64'(0));
        check_readback("midrst", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_mult(32'h00010000, 32'h00010000, -1, -1, sc, bc, dc, dcyc);
        check("postrst.done_cycle", 64'(dcyc), 64'(33));
        check("postrst.hi", 64'(hi_out), 64'(32'h00000001));
        check("postrst.lo", 64'(lo_out), 64'(32'h00000000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
